// File: rtl/usb_buf_pkg.sv
// usb_buf_pkg: shared transfer-size encoding and byte-count helper for the USB data buffer.
// Contents:
//   xfer_size_t    access size code (1, 2, 4 bytes or illegal)
//   size_to_bytes  byte count for a size code, 0 for the illegal code
package usb_buf_pkg;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} xfer_size_t;

   function automatic logic [2:0] size_to_bytes(xfer_size_t s);
      return s == SZ_BYTE ? 3'd1 : s == SZ_HALF ? 3'd2 : s == SZ_WORD ? 3'd4 : 3'd0;
   endfunction
endpackage

// File: rtl/usb_data_buffer_param_if.sv
// usb_data_buffer_param_if: bus bundle between the AHB/serial engines and the USB data buffer.
// Signals:
//   clear                 synchronous flush
//   store_tx_data/tx_data/tx_size            AHB write (1/2/4 bytes, little-endian)
//   get_tx_packet_data/tx_packet_data        TX engine byte pop, show-ahead head byte
//   store_rx_packet_data/rx_packet_data      RX engine byte push
//   get_rx_data/rx_size/rx_data              AHB read (1/2/4 bytes, registered)
//   buffer_occupancy/almost_full/overflow/underflow  status
// Modports: master drives the strobes, slave is the buffer.
interface usb_data_buffer_param_if #(parameter int DEPTH = 64);
   import usb_buf_pkg::*;
   localparam int OW = $clog2(DEPTH) + 1;
   logic          clear;
   logic          store_tx_data;
   logic [31:0]   tx_data;
   xfer_size_t    tx_size;
   logic          get_tx_packet_data;
   logic [7:0]    tx_packet_data;
   logic          store_rx_packet_data;
   logic [7:0]    rx_packet_data;
   logic          get_rx_data;
   xfer_size_t    rx_size;
   logic [31:0]   rx_data;
   logic [OW-1:0] buffer_occupancy;
   logic          almost_full;
   logic          overflow;
   logic          underflow;

   modport master (
      output clear, store_tx_data, tx_data, tx_size, get_tx_packet_data,
             store_rx_packet_data, rx_packet_data, get_rx_data, rx_size,
      input  tx_packet_data, rx_data, buffer_occupancy, almost_full, overflow, underflow
   );

   modport slave (
      input  clear, store_tx_data, tx_data, tx_size, get_tx_packet_data,
             store_rx_packet_data, rx_packet_data, get_rx_data, rx_size,
      output tx_packet_data, rx_data, buffer_occupancy, almost_full, overflow, underflow
   );
endinterface

// File: rtl/usb_buf_ram.sv
// usb_buf_ram: byte memory with four write lanes and four asynchronous read lanes.
// Ports:
//   clk      write clock
//   i_we     per-lane write enable
//   i_waddr  per-lane write address (mod DEPTH)
//   i_wdata  per-lane write byte
//   i_raddr  per-lane read address (mod DEPTH)
//   o_rdata  per-lane read byte, combinational
module usb_buf_ram #(
   parameter int DEPTH = 64
) (
   input  logic                             clk,
   input  logic [3:0]                       i_we,
   input  logic [3:0][$clog2(DEPTH)-1:0]    i_waddr,
   input  logic [3:0][7:0]                  i_wdata,
   input  logic [3:0][$clog2(DEPTH)-1:0]    i_raddr,
   output logic [3:0][7:0]                  o_rdata
);
   logic [7:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++)
         if (i_we[k]) r_mem[i_waddr[k]] <= i_wdata[k];
   end

   always_comb begin
      for (int k = 0; k < 4; k++) o_rdata[k] = r_mem[i_raddr[k]];
   end
endmodule

// File: rtl/usb_data_buffer_param.sv
// usb_data_buffer_param: circular byte FIFO shared by the AHB slave and the USB TX/RX engines.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   usb_data_buffer_param_if.slave: strobes, data, size codes and status
// Pushes and pops are all-or-nothing; rejected accesses pulse overflow/underflow for one cycle.
module usb_data_buffer_param
   import usb_buf_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int HIGH_WM = 48
) (
   input logic                      clk,
   input logic                      rst,
   usb_data_buffer_param_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;

   logic [AW-1:0]       r_wptr;
   logic [AW-1:0]       r_rptr;
   logic [OW-1:0]       r_occ;
   logic [31:0]         r_rx_data;
   logic                r_ovf;
   logic                r_udf;
   logic                r_af;

   logic                w_push_req;
   logic                w_push_ok;
   logic [2:0]          w_push_n;
   logic [2:0]          w_push_acc_n;
   logic                w_pop_req;
   logic                w_pop_ok;
   logic [2:0]          w_pop_req_n;
   logic [2:0]          w_pop_n;
   logic [OW:0]         w_room;
   logic [OW-1:0]       w_occ_next;
   logic [3:0]          w_we;
   logic [3:0][AW-1:0]  w_waddr;
   logic [3:0][AW-1:0]  w_raddr;
   logic [3:0][7:0]     w_wdata;
   logic [3:0][7:0]     w_rdata;
   logic [31:0]         w_rd_word;

   // tx wins the push group, get_rx_data wins the pop group
   assign w_push_req   = bus.store_tx_data | bus.store_rx_packet_data;
   assign w_push_n     = bus.store_tx_data ? size_to_bytes(bus.tx_size) : {2'b00, bus.store_rx_packet_data};
   assign w_pop_req    = bus.get_rx_data | bus.get_tx_packet_data;
   assign w_pop_req_n  = bus.get_rx_data ? size_to_bytes(bus.rx_size) : {2'b00, bus.get_tx_packet_data};

   assign w_pop_ok     = w_pop_req && w_pop_req_n != 3'd0 && {{(OW-3){1'b0}}, w_pop_req_n} <= r_occ;
   assign w_pop_n      = w_pop_ok ? w_pop_req_n : 3'd0;

   // room is checked after the accepted pop has freed its bytes
   assign w_room       = {1'b0, r_occ} - {{(OW-2){1'b0}}, w_pop_n} + {{(OW-2){1'b0}}, w_push_n};
   assign w_push_ok    = w_push_req && w_push_n != 3'd0 && w_room <= (OW+1)'(DEPTH);
   assign w_push_acc_n = w_push_ok ? w_push_n : 3'd0;
   assign w_occ_next   = r_occ - {{(OW-3){1'b0}}, w_pop_n} + {{(OW-3){1'b0}}, w_push_acc_n};

   always_comb begin
      w_rd_word = '0;
      for (int k = 0; k < 4; k++) begin
         w_waddr[k]           = r_wptr + AW'(k);
         w_raddr[k]           = r_rptr + AW'(k);
         w_we[k]              = w_push_ok && !bus.clear && 3'(k) < w_push_n;
         w_wdata[k]           = bus.store_tx_data ? bus.tx_data[8*k +: 8] : bus.rx_packet_data;
         w_rd_word[8*k +: 8]  = 3'(k) < w_pop_n ? w_rdata[k] : 8'h00;
      end
   end

   usb_buf_ram #(.DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_occ     <= '0;
         r_rx_data <= '0;
         r_ovf     <= 1'b0;
         r_udf     <= 1'b0;
         r_af      <= 1'b0;
      end else if (bus.clear) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_occ     <= '0;
         r_ovf     <= 1'b0;
         r_udf     <= 1'b0;
         r_af      <= 1'b0;
      end else begin
         r_wptr    <= r_wptr + AW'(w_push_acc_n);
         r_rptr    <= r_rptr + AW'(w_pop_n);
         r_occ     <= w_occ_next;
         r_ovf     <= (w_push_req && !w_push_ok) || (bus.store_tx_data && bus.store_rx_packet_data);
         r_udf     <= (w_pop_req && !w_pop_ok) || (bus.get_rx_data && bus.get_tx_packet_data);
         r_af      <= w_occ_next >= OW'(HIGH_WM);
         if (bus.get_rx_data && w_pop_ok) r_rx_data <= w_rd_word;
      end
   end

   assign bus.tx_packet_data   = r_occ == '0 ? 8'h00 : w_rdata[0];
   assign bus.rx_data          = r_rx_data;
   assign bus.buffer_occupancy = r_occ;
   assign bus.almost_full      = r_af;
   assign bus.overflow         = r_ovf;
   assign bus.underflow        = r_udf;
endmodule

// File: tb/tb_usb_data_buffer_param.sv
// tb_usb_data_buffer_param: directed and randomized checks of the USB data buffer against a byte-queue model.
module tb_usb_data_buffer_param;
   import usb_buf_pkg::*;
   localparam int DEPTH   = 64;
   localparam int HIGH_WM = 48;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   usb_data_buffer_param_if #(.DEPTH(DEPTH)) bus ();

   usb_data_buffer_param #(.DEPTH(DEPTH), .HIGH_WM(HIGH_WM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int          n_chk = 0;
   int          n_err = 0;
   bit          go = 1'b0;
   logic [7:0]  q[$];
   logic [31:0] m_rx;
   bit          m_ovf, m_udf, m_af, m_ok;
   int          m_pn, m_wn;

   function automatic int nbytes(xfer_size_t s);
      return s == SZ_BYTE ? 1 : s == SZ_HALF ? 2 : s == SZ_WORD ? 4 : 0;
   endfunction

   // reference model: a byte queue, pop applied before push each edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete(); m_rx = 0; m_ovf = 0; m_udf = 0; m_af = 0;
      end else if (bus.clear) begin
         q.delete(); m_ovf = 0; m_udf = 0; m_af = 0;
      end else begin
         m_ovf = 0; m_udf = 0;
         if (bus.get_rx_data) begin
            m_pn = nbytes(bus.rx_size);
            m_ok = m_pn > 0 && m_pn <= q.size();
            m_udf = !m_ok || bus.get_tx_packet_data;
            if (m_ok) begin
               m_rx = 0;
               for (int k = 0; k < m_pn; k++) m_rx[8*k +: 8] = q.pop_front();
            end
         end else if (bus.get_tx_packet_data) begin
            m_ok = q.size() > 0;
            m_udf = !m_ok;
            if (m_ok) void'(q.pop_front());
         end
         if (bus.store_tx_data) begin
            m_wn = nbytes(bus.tx_size);
            m_ok = m_wn > 0 && q.size() + m_wn <= DEPTH;
            m_ovf = !m_ok || bus.store_rx_packet_data;
            if (m_ok) for (int k = 0; k < m_wn; k++) q.push_back(bus.tx_data[8*k +: 8]);
         end else if (bus.store_rx_packet_data) begin
            m_ok = q.size() < DEPTH;
            m_ovf = !m_ok;
            if (m_ok) q.push_back(bus.rx_packet_data);
         end
         m_af = q.size() >= HIGH_WM;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (go) begin
         chk("occupancy", 32'(bus.buffer_occupancy), q.size());
         chk("tx_packet_data", 32'(bus.tx_packet_data), q.size() > 0 ? 32'(q[0]) : 32'h0);
         chk("rx_data", bus.rx_data, m_rx);
         chk("overflow", 32'(bus.overflow), 32'(m_ovf));
         chk("underflow", 32'(bus.underflow), 32'(m_udf));
         chk("almost_full", 32'(bus.almost_full), 32'(m_af));
      end
   end

   task automatic idle();
      bus.clear = 0; bus.store_tx_data = 0; bus.tx_data = 0; bus.tx_size = SZ_BYTE;
      bus.get_tx_packet_data = 0; bus.store_rx_packet_data = 0; bus.rx_packet_data = 0;
      bus.get_rx_data = 0; bus.rx_size = SZ_BYTE;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic push(input logic [31:0] d, input xfer_size_t s);
      bus.store_tx_data = 1; bus.tx_data = d; bus.tx_size = s;
      step();
   endtask

   task automatic popr(input xfer_size_t s);
      bus.get_rx_data = 1; bus.rx_size = s;
      step();
   endtask

   task automatic popt();
      bus.get_tx_packet_data = 1;
      step();
   endtask

   task automatic do_clear();
      bus.clear = 1;
      step();
   endtask

   task automatic fill(input int n);
      for (int r = n; r > 0;) begin
         if (r >= 4) begin push($urandom, SZ_WORD); r -= 4; end
         else if (r >= 2) begin push($urandom, SZ_HALF); r -= 2; end
         else begin push($urandom, SZ_BYTE); r -= 1; end
      end
   endtask

   task automatic drain(input int n);
      for (int r = n; r > 0;) begin
         if (r >= 4) begin popr(SZ_WORD); r -= 4; end
         else if (r >= 2) begin popr(SZ_HALF); r -= 2; end
         else begin popr(SZ_BYTE); r -= 1; end
      end
   endtask

   initial begin
      idle();
      #1 rst = 1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 0;
      go = 1;
      chk("reset occupancy", 32'(bus.buffer_occupancy), 0);
      chk("reset rx_data", bus.rx_data, 0);
      chk("reset flags", {29'b0, bus.overflow, bus.underflow, bus.almost_full}, 0);

      push(32'hDDCCBBAA, SZ_WORD);
      chk("t1 occupancy", 32'(bus.buffer_occupancy), 4);
      chk("t1 byte0", 32'(bus.tx_packet_data), 32'hAA);
      popt();
      chk("t1 byte1", 32'(bus.tx_packet_data), 32'hBB);
      popt();
      chk("t1 byte2", 32'(bus.tx_packet_data), 32'hCC);
      popt();
      chk("t1 byte3", 32'(bus.tx_packet_data), 32'hDD);
      popt();
      chk("t1 empty occupancy", 32'(bus.buffer_occupancy), 0);
      chk("t1 empty head", 32'(bus.tx_packet_data), 0);

      fill(62);
      chk("t2 fill", 32'(bus.buffer_occupancy), 62);
      push(32'h12345678, SZ_WORD);
      chk("t2 overflow", 32'(bus.overflow), 1);
      chk("t2 occupancy held", 32'(bus.buffer_occupancy), 62);
      step();
      chk("t2 overflow pulse ends", 32'(bus.overflow), 0);
      push(32'h0000BEEF, SZ_HALF);
      chk("t2 full", 32'(bus.buffer_occupancy), 64);
      chk("t2 almost_full", 32'(bus.almost_full), 1);
      do_clear();
      chk("clear occupancy", 32'(bus.buffer_occupancy), 0);

      fill(62);
      drain(62);
      push(32'h44332211, SZ_WORD);
      popr(SZ_WORD);
      chk("t3 wrap rx_data", bus.rx_data, 32'h44332211);
      chk("t3 occupancy", 32'(bus.buffer_occupancy), 0);

      fill(10);
      bus.store_tx_data = 1; bus.tx_size = SZ_HALF; bus.tx_data = 32'h0000A5A5;
      bus.get_tx_packet_data = 1;
      step();
      chk("t4 occupancy", 32'(bus.buffer_occupancy), 11);
      chk("t4 no errors", {30'b0, bus.overflow, bus.underflow}, 0);
      do_clear();

      push(32'h77, SZ_BYTE);
      popr(SZ_HALF);
      chk("t5 underflow", 32'(bus.underflow), 1);
      chk("t5 occupancy", 32'(bus.buffer_occupancy), 1);
      chk("t5 rx_data held", bus.rx_data, 32'h44332211);
      bus.clear = 1; bus.store_tx_data = 1; bus.tx_size = SZ_WORD; bus.tx_data = 32'h01020304;
      step();
      chk("t5 clear wins", 32'(bus.buffer_occupancy), 0);
      chk("t5 clear no overflow", 32'(bus.overflow), 0);

      fill(47);
      chk("t6 below mark", 32'(bus.almost_full), 0);
      bus.store_tx_data = 1; bus.tx_size = SZ_BYTE; bus.tx_data = 32'h5A;
      bus.store_rx_packet_data = 1; bus.rx_packet_data = 8'hC3;
      step();
      chk("t6 overflow", 32'(bus.overflow), 1);
      chk("t6 occupancy", 32'(bus.buffer_occupancy), 48);
      chk("t6 almost_full", 32'(bus.almost_full), 1);
      push(32'hFFFFFFFF, SZ_BAD);
      chk("bad tx size overflow", 32'(bus.overflow), 1);
      chk("bad tx size occupancy", 32'(bus.buffer_occupancy), 48);
      popr(SZ_BAD);
      chk("bad rx size underflow", 32'(bus.underflow), 1);
      do_clear();

      for (int i = 0; i < 4000; i++) begin
         int pw;
         pw = ((i / 300) % 2 == 0) ? 60 : 25;
         if (i == 2000) begin
            #2 rst = 1;
            #4 rst = 0;
         end
         bus.store_tx_data = $urandom_range(0, 99) < pw;
         bus.tx_data = $urandom;
         bus.tx_size = $urandom_range(0, 15) == 0 ? SZ_BAD : xfer_size_t'($urandom_range(0, 2));
         bus.store_rx_packet_data = $urandom_range(0, 99) < pw / 2;
         bus.rx_packet_data = 8'($urandom);
         bus.get_rx_data = $urandom_range(0, 99) < (85 - pw) / 2;
         bus.rx_size = $urandom_range(0, 15) == 0 ? SZ_BAD : xfer_size_t'($urandom_range(0, 2));
         bus.get_tx_packet_data = $urandom_range(0, 99) < (85 - pw) / 2;
         bus.clear = $urandom_range(0, 63) == 0;
         step();
      end
      step();
      go = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
